// File: rtl/sd_dat_writer.sv
// DAT0 write-phase engine for 1-bit SD mode: streams one 512-byte sector plus CRC16, then
// parses the CRC status token and waits out card busy. Define SD_DAT_WRITER_TIMEOUT_EN for a token/busy timeout.
module sd_dat_writer #(
    parameter int          CLK_DIV      = 0,
    parameter logic [23:0] BUSY_TIMEOUT = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wstart,
    output logic       wbusy,
    output logic       wdone,
    output logic [2:0] wstatus,
    output logic       werr,
    output logic [8:0] inaddr,
    input  logic [7:0] inbyte,
    output logic       sdclk,
    output logic       sddat0_o,
    output logic       sddat0_oe,
    input  logic       sddat0_i
);

    if (CLK_DIV < 0 || CLK_DIV > 7 || BUSY_TIMEOUT == 24'd0) begin : g_bad_param
        $error("sd_dat_writer: CLK_DIV must be 0..7 and BUSY_TIMEOUT nonzero");
    end

    localparam logic [7:0] HALF_M1 = 8'((1 << CLK_DIV) - 1);

    typedef enum logic [3:0] {IDLE, PRE, START, DATA, CRC, END, STAT, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  div_cnt;
    logic [11:0] cnt;
    logic [7:0]  shreg;
    logic [15:0] crc;
    logic        clk_en, tick, fall, rise, dbit, adv, to_hit;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign clk_en = (state != IDLE) && (state != DONE);
    assign tick   = clk_en && (div_cnt == HALF_M1);
    assign fall   = tick && sdclk;
    assign rise   = tick && !sdclk;
    // Bit 7 of each byte comes straight from the buffer; the rest from the shifter.
    assign dbit   = (cnt[2:0] == 3'd0) ? inbyte[7] : shreg[7];

`ifdef SD_DAT_WRITER_TIMEOUT_EN
    logic [23:0] tcnt;
    assign to_hit = rise && (state == STAT || state == BUSY) && (tcnt == BUSY_TIMEOUT - 24'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  tcnt <= '0;
        else if (state_nxt == STAT && state != STAT) tcnt <= '0;
        else if (rise && (state == STAT || state == BUSY)) tcnt <= tcnt + 24'd1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        case (state)
            IDLE:  if (wstart) state_nxt = PRE;
            PRE:   begin adv = fall; if (fall && cnt == 12'd7)    state_nxt = START; end
            START: if (fall) state_nxt = DATA;
            DATA:  begin adv = fall; if (fall && cnt == 12'd4095) state_nxt = CRC;   end
            CRC:   begin adv = fall; if (fall && cnt == 12'd15)   state_nxt = END;   end
            END:   begin adv = fall; if (fall && cnt == 12'd1)    state_nxt = STAT;  end
            STAT: begin
                // cnt stays 0 until the start bit is seen, then walks the 3 token bits and end bit
                adv = rise && (cnt != 12'd0 || !sddat0_i);
                if (rise && cnt == 12'd4) state_nxt = BUSY;
            end
            BUSY:  if (rise && sddat0_i) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (to_hit) state_nxt = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            sdclk     <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            crc       <= '0;
            sddat0_o  <= 1'b1;
            sddat0_oe <= 1'b0;
            wbusy     <= 1'b0;
            wdone     <= 1'b0;
            wstatus   <= '0;
            werr      <= 1'b0;
            inaddr    <= '0;
        end else begin
            wdone   <= (state_nxt == DONE);
            div_cnt <= (!clk_en || tick) ? 8'd0 : div_cnt + 8'd1;
            sdclk   <= clk_en ? (sdclk ^ tick) : 1'b0;
            cnt     <= (state_nxt != state) ? 12'd0 : (adv ? cnt + 12'd1 : cnt);
            case (state)
                IDLE: if (wstart) begin
                    wbusy   <= 1'b1;
                    werr    <= 1'b0;
                    wstatus <= '0;
                    inaddr  <= '0;
                    crc     <= '0;
                end
                PRE: if (fall) begin
                    sddat0_oe <= 1'b1;
                    sddat0_o  <= 1'b1;
                end
                START: if (fall) sddat0_o <= 1'b0;
                DATA: if (fall) begin
                    sddat0_o <= dbit;
                    crc      <= crc_step(crc, dbit);
                    if (cnt[2:0] == 3'd0) begin
                        shreg  <= {inbyte[6:0], 1'b0};
                        inaddr <= inaddr + 9'd1;
                    end else begin
                        shreg  <= {shreg[6:0], 1'b0};
                    end
                end
                CRC: if (fall) begin
                    sddat0_o <= crc[15];
                    crc      <= {crc[14:0], 1'b0};
                end
                END: if (fall) begin
                    sddat0_o <= 1'b1;
                    if (cnt == 12'd1) sddat0_oe <= 1'b0;
                end
                STAT: if (rise) begin
                    if (cnt >= 12'd1 && cnt <= 12'd3) wstatus <= {wstatus[1:0], sddat0_i};
                    if (cnt == 12'd4) werr <= (wstatus != 3'b010);
                end
                DONE: wbusy <= 1'b0;
                default: ;
            endcase
            if (to_hit) begin
                werr    <= 1'b1;
                wstatus <= 3'b111;
            end
        end
    end

endmodule

// File: tb/tb_sd_dat_writer.sv
// Randomized bench for sd_dat_writer: a frame-level model plus a card model on DAT0, one DUT at
// CLK_DIV=0 and one at CLK_DIV=2 sharing the card; timeout case runs when SD_DAT_WRITER_TIMEOUT_EN is defined.
module tb_sd_dat_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic sel = 1'b0, wstart = 1'b0, card_din = 1'b1;

    logic       wbusy0, wdone0, werr0, sdclk0, o0, oe0;
    logic [2:0] wstatus0;
    logic [8:0] inaddr0;
    logic [7:0] inbyte0 = 8'h00;
    logic       wbusy2, wdone2, werr2, sdclk2, o2, oe2;
    logic [2:0] wstatus2;
    logic [8:0] inaddr2;
    logic [7:0] inbyte2 = 8'h00;
    logic       wstart0, wstart2, din0, din2;

    assign wstart0 = wstart & ~sel;
    assign wstart2 = wstart & sel;
    assign din0    = sel ? 1'b1 : card_din;
    assign din2    = sel ? card_din : 1'b1;

    sd_dat_writer #(.CLK_DIV(0), .BUSY_TIMEOUT(24'd100)) u0 (
        .clk(clk), .rst(rst), .wstart(wstart0), .wbusy(wbusy0), .wdone(wdone0),
        .wstatus(wstatus0), .werr(werr0), .inaddr(inaddr0), .inbyte(inbyte0),
        .sdclk(sdclk0), .sddat0_o(o0), .sddat0_oe(oe0), .sddat0_i(din0));

    sd_dat_writer #(.CLK_DIV(2), .BUSY_TIMEOUT(24'd100)) u2 (
        .clk(clk), .rst(rst), .wstart(wstart2), .wbusy(wbusy2), .wdone(wdone2),
        .wstatus(wstatus2), .werr(werr2), .inaddr(inaddr2), .inbyte(inbyte2),
        .sdclk(sdclk2), .sddat0_o(o2), .sddat0_oe(oe2), .sddat0_i(din2));

    logic       m_wbusy, m_wdone, m_werr, m_sdclk, m_o, m_oe;
    logic [2:0] m_wstatus;
    logic [8:0] m_inaddr;
    assign m_wbusy   = sel ? wbusy2   : wbusy0;
    assign m_wdone   = sel ? wdone2   : wdone0;
    assign m_werr    = sel ? werr2    : werr0;
    assign m_sdclk   = sel ? sdclk2   : sdclk0;
    assign m_o       = sel ? o2       : o0;
    assign m_oe      = sel ? oe2      : oe0;
    assign m_wstatus = sel ? wstatus2 : wstatus0;
    assign m_inaddr  = sel ? inaddr2  : inaddr0;

    // Synchronous sector buffer: data one clk after the address.
    logic [7:0] mem [0:511];
    always @(posedge clk) begin
        inbyte0 <= mem[inaddr0];
        inbyte2 <= mem[inaddr2];
    end

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference frame: 8 ones, start 0, 4096 data bits MSB first, CRC16 MSB first, end 1.
    bit          exp_frame [0:4121];
    logic [15:0] exp_crc;

    function automatic logic [15:0] crc_model();
        logic [15:0] c = 16'h0000;
        logic        fb;
        for (int b = 0; b < 512; b++)
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ mem[b][j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        return c;
    endfunction

    task automatic build_frame();
        exp_crc = crc_model();
        for (int i = 0; i < 8; i++) exp_frame[i] = 1'b1;
        exp_frame[8] = 1'b0;
        for (int b = 0; b < 512; b++)
            for (int j = 0; j < 8; j++) exp_frame[9 + b*8 + j] = mem[b][7-j];
        for (int j = 0; j < 16; j++) exp_frame[4105 + j] = exp_crc[15-j];
        exp_frame[4121] = 1'b1;
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 512; i++)
            case (pat)
                0: mem[i] = 8'h00;
                1: mem[i] = 8'hFF;
                2: mem[i] = 8'(i);
                default: mem[i] = 8'($urandom_range(0, 255));
            endcase
    endtask

    // Monitor / card state
    bit          mon_on = 1'b0;
    bit          card_q[$];
    bit          card_dflt = 1'b1;
    int          bit_idx, oe_rises, rel_rises, addr_steps, last_rise, half = 1;
    int          clk_cnt = 0;
    logic        prev_sdclk = 1'b0;
    logic [8:0]  prev_addr = 9'd0, nxt_addr;
    logic [15:0] rx_crc;

    always @(negedge clk) begin
        clk_cnt++;
        if (mon_on) begin
            if (m_sdclk && !prev_sdclk) begin
                if (last_rise >= 0) chk("sdclk_period", clk_cnt - last_rise, 2 * half);
                last_rise = clk_cnt;
                if (m_oe) begin
                    oe_rises++;
                    if (bit_idx < 4122) begin
                        chk("dat0_bit", m_o, exp_frame[bit_idx]);
                        if (bit_idx >= 4105 && bit_idx <= 4120) rx_crc = {rx_crc[14:0], m_o};
                        bit_idx++;
                    end
                end else if (bit_idx == 4122) rel_rises++;
            end
            // Card drives its response on SD clock falls once the host frame is complete.
            if (!m_sdclk && prev_sdclk && bit_idx == 4122)
                card_din = (card_q.size() > 0) ? card_q.pop_front() : card_dflt;
            if (m_inaddr != prev_addr) begin
                nxt_addr = prev_addr + 9'd1;
                chk("inaddr_step", m_inaddr, nxt_addr);
                addr_steps++;
                prev_addr = m_inaddr;
            end
        end
        prev_sdclk = m_sdclk;
    end

    task automatic set_card(input logic [2:0] tok, input int busy_len, input bit hold_low);
        card_q.delete();
        card_dflt = !hold_low;
        if (!hold_low) begin
            repeat ($urandom_range(0, 3)) card_q.push_back(1'b1);
            card_q.push_back(1'b0);
            card_q.push_back(tok[2]);
            card_q.push_back(tok[1]);
            card_q.push_back(tok[0]);
            card_q.push_back(1'b1);
            repeat (busy_len) card_q.push_back(1'b0);
        end
    endtask

    task automatic start_xfer(input bit s, input int pat);
        @(negedge clk);
        sel  = s;
        half = s ? 4 : 1;
        fill(pat);
        build_frame();
        bit_idx = 0; oe_rises = 0; rel_rises = 0; addr_steps = 0; last_rise = -1;
        rx_crc = 16'h0; prev_addr = m_inaddr; card_din = 1'b1;
        mon_on = 1'b1;
        wstart = 1'b1;
        @(negedge clk);
        wstart = 1'b0;
        chk("wbusy_after_start", m_wbusy, 1'b1);
    endtask

    task automatic wait_addr(input int n);
        int k = 0;
        while (m_inaddr < 9'(n) && k < 6000) begin @(negedge clk); k++; end
        if (k >= 6000) chk("wait_inaddr_timeout", 0, 1);
    endtask

    task automatic finish_xfer(input bit exp_werr, input logic [2:0] exp_stat, input bit hold_low);
        int lim = 4400 * 2 * half;
        bit got = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (m_wdone) begin got = 1'b1; break; end
        end
        if (!got) begin
            chk("wdone_timeout", 0, 1);
            mon_on = 1'b0;
            return;
        end
        chk("wbusy_at_wdone", m_wbusy, 1'b1);
        #1;
        chk("werr", m_werr, exp_werr);
        chk("wstatus", m_wstatus, exp_stat);
        chk("frame_bits_seen", bit_idx, 4122);
        chk("oe_sd_clocks", oe_rises, 4122);
        chk("inaddr_steps", addr_steps, 512);
        if (hold_low) chk("timeout_sd_clocks", rel_rises, 100);
        else          chk("card_bits_left", card_q.size(), 0);
        @(negedge clk);
        chk("wdone_one_clk", m_wdone, 1'b0);
        chk("wbusy_after_done", m_wbusy, 1'b0);
        chk("sdclk_idle_low", m_sdclk, 1'b0);
        chk("oe_idle", m_oe, 1'b0);
        mon_on = 1'b0;
    endtask

    initial begin
        fill(0);
        repeat (3) @(negedge clk);
        chk("rst_sdclk", sdclk0, 1'b0);
        chk("rst_o", o0, 1'b1);
        chk("rst_oe", oe0, 1'b0);
        chk("rst_wbusy", wbusy0, 1'b0);
        chk("rst_wdone", wdone0, 1'b0);
        chk("rst_wstatus", wstatus0, 3'b000);
        chk("rst_werr", werr0, 1'b0);
        chk("rst_inaddr", inaddr0, 9'd0);
        chk("rst_oe_div2", oe2, 1'b0);
        chk("rst_sdclk_div2", sdclk2, 1'b0);
        rst = 1'b0;

        // Zero buffer, good token, 20 busy clocks
        set_card(3'b010, 20, 1'b0);
        start_xfer(1'b0, 0);
        chk("model_crc_zero", exp_crc, 16'h0000);
        finish_xfer(1'b0, 3'b010, 1'b0);
        chk("rx_crc_zero", rx_crc, 16'h0000);

        // All-0xFF buffer pins the CRC
        set_card(3'b010, $urandom_range(1, 30), 1'b0);
        start_xfer(1'b0, 1);
        chk("model_crc_ff", exp_crc, 16'h7FA1);
        finish_xfer(1'b0, 3'b010, 1'b0);
        chk("rx_crc_ff", rx_crc, 16'h7FA1);

        // Ramp buffer at CLK_DIV=2
        set_card(3'b010, $urandom_range(1, 30), 1'b0);
        start_xfer(1'b1, 2);
        finish_xfer(1'b0, 3'b010, 1'b0);

        // Random buffer, bad token, wstart re-pulsed mid-data
        set_card(3'b101, 20, 1'b0);
        start_xfer(1'b0, 3);
        wait_addr(50);
        @(negedge clk); wstart = 1'b1;
        @(negedge clk); wstart = 1'b0;
        finish_xfer(1'b1, 3'b101, 1'b0);

        // Reset in the middle of the data phase
        set_card(3'b010, 5, 1'b0);
        start_xfer(1'b0, 3);
        wait_addr(100);
        @(negedge clk);
        mon_on = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_oe", m_oe, 1'b0);
        chk("midrst_wbusy", m_wbusy, 1'b0);
        chk("midrst_sdclk", m_sdclk, 1'b0);
        chk("midrst_o", m_o, 1'b1);
        chk("midrst_inaddr", m_inaddr, 9'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fresh transfer after reset
        set_card(3'b010, $urandom_range(1, 30), 1'b0);
        start_xfer(1'b0, 3);
        finish_xfer(1'b0, 3'b010, 1'b0);

`ifdef SD_DAT_WRITER_TIMEOUT_EN
        // Card never releases DAT0
        set_card(3'b000, 0, 1'b1);
        start_xfer(1'b0, 3);
        finish_xfer(1'b1, 3'b111, 1'b1);
        card_din = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
